// File: rtl/rv32i_dmem_responder.sv
// rv32i_dmem_responder
//
// Data-memory responder for the memory-access stage stb/ack bus. The responder
// takes one request at a time. It waits a fixed number of cycles, then commits a
// masked word write or a word read to the internal RAM. The ack is a single-cycle
// pulse. Read data is returned as a full word; the requester selects bytes or halves.
//
// state  | meaning
// -------+------------------------------------------------------------------
// IDLE   | no request pending; a strobe is accepted unless the ack is high
// WAIT   | request latched; counting down the wait states
// RESP   | commit edge pending; the next edge writes or reads RAM and raises ack

module rv32i_dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stb_data,
    input  logic        i_wr_mem,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data_store,
    input  logic [3:0]  i_wr_mask,
    output logic        o_ack_data,
    output logic [31:0] o_din,
    output logic        o_err,
    output logic        o_busy
);

    localparam int unsigned AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  mask_q, mask_d;
    logic        we_q, we_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    logic        busy_q, busy_d;
    logic [31:0] din_q, din_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0] word_off;
    logic        in_range;
    logic [AW-1:0] idx;
    logic [31:0] rd_word;
    logic        accept;
    logic        commit;

    // Address decode of the latched request: word offset from the base and range check
    always_comb begin
        word_off = (addr_q - BASE_ADDR) >> 2;
        in_range = (addr_q >= BASE_ADDR) && (word_off < DEPTH_WORDS);
        idx      = word_off[AW-1:0];
        rd_word  = mem[idx];
        // Accept only with no request in flight. busy_q is still high during the ack cycle,
        // so a strobe in that cycle is dropped as well.
        accept   = i_stb_data && !busy_q && (state_q == ST_IDLE);
        commit   = (state_q == ST_RESP);
    end

    // Next-state and output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        mask_d  = mask_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        din_d   = din_q;

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    addr_d  = i_addr;
                    wdata_d = i_data_store;
                    mask_d  = i_wr_mask;
                    we_d    = i_wr_mem;
                    if (WAIT_CYCLES == 0) begin
                        state_d = ST_RESP;
                        cnt_d   = 4'd0;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = WAIT_CNT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = ST_RESP;
                    cnt_d   = 4'd0;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                ack_d   = 1'b1;
                err_d   = !in_range;
                if (!we_q) begin
                    din_d = in_range ? rd_word : 32'h0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = 4'd0;
            end
        endcase

        // busy stays high through the ack cycle even though the FSM is already back in IDLE
        busy_d = (state_d != ST_IDLE) || ack_d;
    end

    // State and output registers, synchronous reset has priority over the strobe
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            mask_q  <= 4'h0;
            we_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            din_q   <= 32'h0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            mask_q  <= mask_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            din_q   <= din_d;
        end
    end

    // RAM byte-masked write on the commit edge. Contents are not cleared by reset,
    // and a reset on the commit edge aborts the write.
    always_ff @(posedge i_clk) begin
        if (!i_rst && commit && we_q && in_range) begin
            for (int k = 0; k < 4; k++) begin
                if (mask_q[k]) begin
                    mem[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
            end
        end
    end

    assign o_ack_data = ack_q;
    assign o_err      = err_q;
    assign o_busy     = busy_q;
    assign o_din      = din_q;

endmodule

// File: tb/tb_rv32i_dmem_responder.sv
// Directed testbench for rv32i_dmem_responder. Four instances share the clock and the
// request fields; each instance has its own strobe and reset and a different wait-state count.
// Instance wait states: 0 -> 1, 1 -> 3, 2 -> 0, 3 -> 4. All use DEPTH=16 and BASE=0x1000.

module tb_rv32i_dmem_responder;

    localparam int          NDUT  = 4;
    localparam int          DEPTH = 16;
    localparam logic [31:0] BASE  = 32'h0000_1000;
    localparam int          W_TAB [NDUT] = '{1, 3, 0, 4};

    logic        clk = 1'b0;
    logic [3:0]  rst;
    logic [3:0]  stb;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [3:0]  ack;
    logic [3:0]  err;
    logic [3:0]  busy;
    logic [31:0] din [NDUT];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(1)) u_w1 (
        .i_clk(clk), .i_rst(rst[0]), .i_stb_data(stb[0]), .i_wr_mem(we), .i_addr(addr),
        .i_data_store(wdata), .i_wr_mask(mask), .o_ack_data(ack[0]), .o_din(din[0]),
        .o_err(err[0]), .o_busy(busy[0]));

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(3)) u_w3 (
        .i_clk(clk), .i_rst(rst[1]), .i_stb_data(stb[1]), .i_wr_mem(we), .i_addr(addr),
        .i_data_store(wdata), .i_wr_mask(mask), .o_ack_data(ack[1]), .o_din(din[1]),
        .o_err(err[1]), .o_busy(busy[1]));

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(0)) u_w0 (
        .i_clk(clk), .i_rst(rst[2]), .i_stb_data(stb[2]), .i_wr_mem(we), .i_addr(addr),
        .i_data_store(wdata), .i_wr_mask(mask), .o_ack_data(ack[2]), .o_din(din[2]),
        .o_err(err[2]), .o_busy(busy[2]));

    rv32i_dmem_responder #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE), .WAIT_CYCLES(4)) u_w4 (
        .i_clk(clk), .i_rst(rst[3]), .i_stb_data(stb[3]), .i_wr_mem(we), .i_addr(addr),
        .i_data_store(wdata), .i_wr_mask(mask), .o_ack_data(ack[3]), .o_din(din[3]),
        .o_err(err[3]), .o_busy(busy[3]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request. It checks busy after acceptance, the stb-to-ack edge count,
    // busy in the ack cycle, and that ack lasts a single cycle. It returns din and err
    // as sampled in the ack cycle.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] m, input string tag,
                          output logic [31:0] rd, output logic e);
        int lat;
        stb[d] = 1'b1;
        we     = w;
        addr   = a;
        wdata  = wd;
        mask   = m;
        tick();
        stb[d] = 1'b0;
        chk({tag, "_busy"}, 32'(busy[d]), 32'd1);
        lat = 0;
        while (lat < 40) begin
            tick();
            lat++;
            if (ack[d]) break;
        end
        chk({tag, "_lat"}, 32'(lat), 32'(W_TAB[d] + 1));
        chk({tag, "_busy_ack"}, 32'(busy[d]), 32'd1);
        rd = din[d];
        e  = err[d];
        tick();
        chk({tag, "_ackw"}, 32'(ack[d]), 32'd0);
        chk({tag, "_idle"}, 32'(busy[d]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        logic        e;
        int          acks;

        rst   = 4'hF;
        stb   = 4'h0;
        we    = 1'b0;
        addr  = 32'h0;
        wdata = 32'h0;
        mask  = 4'h0;
        tick();
        tick();
        rst = 4'h0;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_ack%0d", d), 32'(ack[d]), 32'd0);
            chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
            chk($sformatf("rst_err%0d", d), 32'(err[d]), 32'd0);
            chk($sformatf("rst_din%0d", d), din[d], 32'h0);
        end
        tick();

        // Write a full word, then read it back
        do_req(0, 1'b1, BASE + 32'h10, 32'hDEADBEEF, 4'hF, "t1_wr", rd, e);
        chk("t1_wr_err", 32'(e), 32'd0);
        do_req(0, 1'b0, BASE + 32'h10, 32'h0, 4'h0, "t1_rd", rd, e);
        chk("t1_rd_din", rd, 32'hDEADBEEF);
        chk("t1_rd_err", 32'(e), 32'd0);

        // Byte-masked writes merge into the existing word
        do_req(0, 1'b1, BASE + 32'h20, 32'h11223344, 4'hF, "t2_init", rd, e);
        do_req(0, 1'b1, BASE + 32'h20, 32'h0000AA00, 4'b0010, "t2_m2", rd, e);
        do_req(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, "t2_rd1", rd, e);
        chk("t2_rd1_din", rd, 32'h1122AA44);
        do_req(0, 1'b1, BASE + 32'h20, 32'hBBBB0000, 4'b1100, "t2_mc", rd, e);
        do_req(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, "t2_rd2", rd, e);
        chk("t2_rd2_din", rd, 32'hBBBBAA44);
        do_req(0, 1'b1, BASE + 32'h20, 32'hFFFFFFFF, 4'h0, "t2_m0", rd, e);
        do_req(0, 1'b0, BASE + 32'h20, 32'h0, 4'h0, "t2_rd3", rd, e);
        chk("t2_rd3_din", rd, 32'hBBBBAA44);

        // Out-of-range accesses above the top and below the base
        do_req(0, 1'b1, BASE, 32'hA5A5A5A5, 4'hF, "t3_w0", rd, e);
        do_req(0, 1'b1, BASE + 32'(4 * (DEPTH - 1)), 32'h5A5A5A5A, 4'hF, "t3_wl", rd, e);
        do_req(0, 1'b0, BASE + 32'(4 * DEPTH), 32'h0, 4'h0, "t3_rd_oor", rd, e);
        chk("t3_rd_oor_err", 32'(e), 32'd1);
        chk("t3_rd_oor_din", rd, 32'h0);
        do_req(0, 1'b1, BASE + 32'(4 * DEPTH), 32'hFFFFFFFF, 4'hF, "t3_wr_oor", rd, e);
        chk("t3_wr_oor_err", 32'(e), 32'd1);
        do_req(0, 1'b0, BASE, 32'h0, 4'h0, "t3_rd0", rd, e);
        chk("t3_rd0_din", rd, 32'hA5A5A5A5);
        do_req(0, 1'b0, BASE + 32'(4 * (DEPTH - 1)), 32'h0, 4'h0, "t3_rdl", rd, e);
        chk("t3_rdl_din", rd, 32'h5A5A5A5A);
        do_req(0, 1'b0, BASE - 32'h4, 32'h0, 4'h0, "t3_rd_low", rd, e);
        chk("t3_rd_low_err", 32'(e), 32'd1);
        chk("t3_rd_low_din", rd, 32'h0);

        // A strobe while busy is dropped
        do_req(0, 1'b1, BASE + 32'h34, 32'h0, 4'hF, "t4_pre", rd, e);
        stb[0] = 1'b1;
        we     = 1'b1;
        addr   = BASE + 32'h30;
        wdata  = 32'h01010101;
        mask   = 4'hF;
        tick();
        addr   = BASE + 32'h34;
        wdata  = 32'h02020202;
        tick();
        stb[0] = 1'b0;
        acks = 0;
        repeat (8) begin
            if (ack[0]) acks++;
            tick();
        end
        chk("t4_acks", 32'(acks), 32'd1);
        do_req(0, 1'b0, BASE + 32'h30, 32'h0, 4'h0, "t4_rd30", rd, e);
        chk("t4_rd30_din", rd, 32'h01010101);
        do_req(0, 1'b0, BASE + 32'h34, 32'h0, 4'h0, "t4_rd34", rd, e);
        chk("t4_rd34_din", rd, 32'h0);

        // A strobe present during the ack cycle is dropped
        stb[0] = 1'b1;
        we     = 1'b1;
        addr   = BASE + 32'h34;
        wdata  = 32'h03030303;
        mask   = 4'hF;
        tick();
        stb[0] = 1'b0;
        tick();
        tick();
        chk("t4b_ack", 32'(ack[0]), 32'd1);
        stb[0] = 1'b1;
        addr   = BASE + 32'h30;
        wdata  = 32'hFFFFFFFF;
        tick();
        stb[0] = 1'b0;
        acks = 0;
        repeat (6) begin
            if (ack[0]) acks++;
            tick();
        end
        chk("t4b_acks", 32'(acks), 32'd0);
        do_req(0, 1'b0, BASE + 32'h30, 32'h0, 4'h0, "t4b_rd30", rd, e);
        chk("t4b_rd30_din", rd, 32'h01010101);
        do_req(0, 1'b0, BASE + 32'h34, 32'h0, 4'h0, "t4b_rd34", rd, e);
        chk("t4b_rd34_din", rd, 32'h03030303);

        // Reset one edge after a write strobe aborts the write (wait states = 3)
        do_req(1, 1'b1, BASE + 32'h8, 32'h12345678, 4'hF, "t5_wr", rd, e);
        do_req(1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, "t5_rd", rd, e);
        chk("t5_rd_din", rd, 32'h12345678);
        stb[1] = 1'b1;
        we     = 1'b1;
        addr   = BASE + 32'h8;
        wdata  = 32'hFFFFFFFF;
        mask   = 4'hF;
        tick();
        stb[1] = 1'b0;
        rst[1] = 1'b1;
        tick();
        rst[1] = 1'b0;
        chk("t5_rst_ack", 32'(ack[1]), 32'd0);
        chk("t5_rst_busy", 32'(busy[1]), 32'd0);
        chk("t5_rst_err", 32'(err[1]), 32'd0);
        chk("t5_rst_din", din[1], 32'h0);
        acks = 0;
        repeat (8) begin
            if (ack[1]) acks++;
            tick();
        end
        chk("t5_acks", 32'(acks), 32'd0);
        do_req(1, 1'b0, BASE + 32'h8, 32'h0, 4'h0, "t5_rd2", rd, e);
        chk("t5_rd2_din", rd, 32'h12345678);

        // Wait-state sweep: zero and four wait states; din holds across a write and idle cycles
        do_req(2, 1'b1, BASE + 32'h4, 32'hCAFEF00D, 4'hF, "t6_w0_wr", rd, e);
        do_req(2, 1'b0, BASE + 32'h4, 32'h0, 4'h0, "t6_w0_rd", rd, e);
        chk("t6_w0_din", rd, 32'hCAFEF00D);
        do_req(3, 1'b1, BASE + 32'h4, 32'h0BADC0DE, 4'hF, "t6_w4_wr", rd, e);
        do_req(3, 1'b0, BASE + 32'h4, 32'h0, 4'h0, "t6_w4_rd", rd, e);
        chk("t6_w4_din", rd, 32'h0BADC0DE);
        do_req(3, 1'b1, BASE + 32'h8, 32'h0, 4'hF, "t6_w4_wr2", rd, e);
        chk("t6_hold_wr", rd, 32'h0BADC0DE);
        repeat (5) tick();
        chk("t6_hold_idle", din[3], 32'h0BADC0DE);
        do_req(3, 1'b0, BASE + 32'h8, 32'h0, 4'h0, "t6_w4_rd2", rd, e);
        chk("t6_w4_din2", rd, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
